// File: rtl/note_scroller.sv
// Per-frame falling-note engine: moves up to NUM_SLOTS notes, judges key presses
// against the hit window and keeps score/combo for the HUD.
module note_scroller #(
    parameter int NUM_SLOTS  = 8,
    parameter int NOTE_SPEED = 2,
    parameter int SPAWN_Y    = 0,
    parameter int HIT_Y      = 420,
    parameter int HIT_WIN    = 12
) (
    input  logic                    frame_clk,
    input  logic                    Reset,
    input  logic [7:0]              keycode,
    input  logic [9:0]              lane_x0,
    input  logic [9:0]              lane_x1,
    input  logic [9:0]              lane_x2,
    input  logic [9:0]              lane_x3,
    input  logic [9:0]              lane_x4,
    input  logic                    spawn_valid,
    input  logic [2:0]              spawn_lane,
    output logic                    spawn_ready,
    output logic [NUM_SLOTS-1:0]    note_active,
    output logic [10*NUM_SLOTS-1:0] note_x,
    output logic [10*NUM_SLOTS-1:0] note_y,
    output logic                    hit_pulse,
    output logic                    miss_pulse,
    output logic [15:0]             score,
    output logic [7:0]              combo
);

    localparam int         IDXW   = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam logic [9:0] WIN_LO = 10'(HIT_Y - HIT_WIN);
    localparam logic [9:0] WIN_HI = 10'(HIT_Y + HIT_WIN);
    localparam logic [9:0] SPEED  = 10'(NOTE_SPEED);
    localparam logic [9:0] START  = 10'(SPAWN_Y);

    logic [NUM_SLOTS-1:0] active;
    logic [2:0]           lane [NUM_SLOTS];
    logic [9:0]           y    [NUM_SLOTS];
    logic [7:0]           key_prev;

    logic                 press;
    logic [2:0]           press_lane;
    logic [NUM_SLOTS-1:0] miss_vec;
    logic [NUM_SLOTS-1:0] cand_vec;
    logic                 hit_found;
    logic [IDXW-1:0]      hit_idx;
    logic                 free_found;
    logic [IDXW-1:0]      free_idx;
    logic                 spawn_write;
    logic [16:0]          score_sum;
    logic [15:0]          score_next;

    // A press is only the first frame a new nonzero keycode appears; unmapped keys are ignored.
    always_comb begin
        press      = 1'b0;
        press_lane = 3'd0;
        if (keycode != 8'h00 && keycode != key_prev) begin
            case (keycode)
                8'h04: begin press = 1'b1; press_lane = 3'd0; end
                8'h16: begin press = 1'b1; press_lane = 3'd1; end
                8'h07: begin press = 1'b1; press_lane = 3'd2; end
                8'h0D: begin press = 1'b1; press_lane = 3'd3; end
                8'h0E: begin press = 1'b1; press_lane = 3'd4; end
                default: ;
            endcase
        end
    end

    always_comb begin
        miss_vec = '0;
        cand_vec = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            miss_vec[i] = active[i] && (y[i] > WIN_HI);
            cand_vec[i] = press && active[i] && (lane[i] == press_lane) &&
                          (y[i] >= WIN_LO) && (y[i] <= WIN_HI);
        end
    end

    // Scanning downward lets the lowest-index match win for both hits and free slots.
    always_comb begin
        hit_found  = 1'b0;
        hit_idx    = '0;
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (cand_vec[i]) begin
                hit_found = 1'b1;
                hit_idx   = IDXW'(i);
            end
            if (!active[i]) begin
                free_found = 1'b1;
                free_idx   = IDXW'(i);
            end
        end
    end

    assign spawn_ready = free_found;
    assign spawn_write = spawn_valid && free_found && (spawn_lane <= 3'd4);

    always_comb begin
        score_sum  = {1'b0, score} + ((combo >= 8'd10) ? 17'd20 : 17'd10);
        score_next = score_sum[16] ? 16'hFFFF : score_sum[15:0];
    end

    always_ff @(posedge frame_clk) begin
        if (!Reset) begin
            active     <= '0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                lane[i] <= 3'd0;
                y[i]    <= 10'd0;
            end
            score      <= 16'd0;
            combo      <= 8'd0;
            hit_pulse  <= 1'b0;
            miss_pulse <= 1'b0;
            key_prev   <= 8'h00;
        end else begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (active[i]) begin
                    if (miss_vec[i]) begin
                        active[i] <= 1'b0;
                    end else if (hit_found && hit_idx == IDXW'(i)) begin
                        active[i] <= 1'b0;
                    end else begin
                        y[i] <= y[i] + SPEED;
                    end
                end
            end
            // The chosen slot was inactive before this edge, so it never collides with the update above.
            if (spawn_write) begin
                active[free_idx] <= 1'b1;
                lane[free_idx]   <= spawn_lane;
                y[free_idx]      <= START;
            end
            hit_pulse  <= hit_found;
            miss_pulse <= |miss_vec;
            if (hit_found) begin
                score <= score_next;
            end
            if (|miss_vec) begin
                combo <= 8'd0;
            end else if (hit_found && combo != 8'hFF) begin
                combo <= combo + 8'd1;
            end
            key_prev <= keycode;
        end
    end

    always_comb begin
        note_active = active;
        note_x      = '0;
        note_y      = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (active[i]) begin
                case (lane[i])
                    3'd0:    note_x[10*i +: 10] = lane_x0;
                    3'd1:    note_x[10*i +: 10] = lane_x1;
                    3'd2:    note_x[10*i +: 10] = lane_x2;
                    3'd3:    note_x[10*i +: 10] = lane_x3;
                    3'd4:    note_x[10*i +: 10] = lane_x4;
                    default: note_x[10*i +: 10] = 10'd0;
                endcase
                note_y[10*i +: 10] = y[i];
            end
        end
    end

endmodule
